cu_edge_data_accumulate_control: RTL
====================================

Name: cu_edge_data_accumulate_control

Overview:
- Sits directly downstream of the edge-data read stage in the CSR PageRank push compute unit.
- Consumes its per-edge (dest id, data) stream, which cannot be back-pressured.
- Coalesces consecutive updates to the same destination vertex into one running sum.
- Queues completed sums in an output FIFO that feeds the vertex write-command stage, and provides flush/done handshaking for end-of-iteration drain.

Parameters:
- DATA_W, 32: width of edge data and accumulated sum (fixed-point, unsigned, wraps mod 2^DATA_W).
- ID_W, 32: destination vertex id width.
- CU_ID_W, 8: compute-unit id width.
- FIFO_DEPTH, 16: output FIFO entries (power of two).
- ALMOST_FULL_TH, 12: occupancy at or above which almost_full_out asserts.

Ports:
- clock  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- enabled_in  in  1  block enable (registered internally, one cycle delay).
- edge_valid_in  in  1  edge record valid (no ready; every valid cycle must be taken).
- edge_cu_id_in  in  CU_ID_W  originating cu id.
- edge_id_in  in  ID_W  destination vertex id.
- edge_data_in  in  DATA_W  contribution value (already endian-corrected).
- flush_in  in  1  level; drain accumulator and FIFO.
- write_ready_in  in  1  downstream accepts the head entry.
- write_valid_out  out  1  head entry valid.
- write_cu_id_out  out  CU_ID_W  cu id of the head entry.
- write_id_out  out  ID_W  vertex id of the head entry.
- write_data_out  out  DATA_W  accumulated sum of the head entry.
- almost_full_out  out  1  FIFO occupancy >= ALMOST_FULL_TH (read-request throttle).
- overflow_out  out  1  sticky: an eviction was dropped.
- done_out  out  1  flush complete.
- edge_count_out  out  32  number of accepted edge records (wraps).

Behaviour:
- Reset: every output is 0. FIFO is empty, accumulator is invalid, state is IDLE.
- enabled is enabled_in delayed one flop. While enabled=0:
  - all state holds and input is ignored;
  - write_valid_out is forced 0 and no pop occurs;
  - other outputs hold.
- Stage 1: at edge t, if enabled, register edge_*_in. The stage-1 valid bit is cleared when edge_valid_in=0.
- Stage 2, at edge t+1 with stage-1 valid:
  - Accumulator invalid: load id, cu_id and data; set valid.
  - Accumulator valid and id equal: sum <= sum + data (DATA_W wrap, no saturation). cu_id is kept from the first record.
  - Accumulator valid and id differs: evict (push {cu_id, id, sum}) and load the new record in the same cycle.
  - edge_count_out increments for each stage-1 valid.
- FIFO:
  - write_* outputs present the head entry combinationally from storage.
  - write_valid_out = not empty and enabled.
  - Pop on write_valid_out and write_ready_in.
  - Push and pop in the same cycle is allowed, including when full: pop first, occupancy unchanged.
  - Push when full with no pop: the entry is dropped, overflow_out sets, and it stays set until reset.
- Latency: a record sampled at edge t that is evicted at edge t+1 drives write_valid_out in the following cycle (2 cycles minimum if the FIFO was empty).
- State machine:
  - IDLE: accumulator invalid. Goes to ACCUM on the first stage-1 valid.
  - ACCUM: normal operation. Goes to FLUSH when flush_in=1.
  - FLUSH:
    - Incoming records are still processed normally and take priority over the flush eviction.
    - In a cycle with no stage-1 valid and the accumulator valid, push the accumulator and clear it.
    - Goes to DONE when stage 1 is empty, the accumulator is invalid and the FIFO is empty.
  - DONE: done_out=1. On flush_in=0 go to IDLE and clear done_out. A new record arriving in DONE returns the FSM to FLUSH with done_out=0.
- flush_in seen in IDLE with everything empty: go to FLUSH, then DONE the next cycle.
- The last record of a run of identical ids is only emitted on an id change or during FLUSH; it never times out.
- Reset mid-operation clears all in-flight data without emitting it.

Test Plan:
- Single merge: after reset, records (id 5, 10), (id 5, 20), (id 5, 12) on consecutive cycles, then flush_in=1 with write_ready_in=1 → exactly one write {id 5, data 42}; done_out rises; edge_count_out=3.
- Eviction latency: (id 1, 7) at edge t, (id 2, 3) at edge t+1, ready=1 → write {id 1, 7} valid in the cycle after edge t+2. {id 2, 3} appears only after flush.
- Wrap: (id 9, 0xFFFFFFF0) then (id 9, 0x20), then flush → write_data_out=0x00000010.
- Back-pressure/overflow: write_ready_in=0 and 18 alternating ids:
  - almost_full_out asserts when occupancy reaches 12;
  - the FIFO holds 16;
  - overflow_out sets on the 17th eviction and stays set after ready returns.
- Simultaneous push/pop at full: FIFO full, ready=1, new-id record → one pop and one push in the same cycle; occupancy stays 16; no overflow.
- Enable/reset: enabled_in=0 mid-stream → write_valid_out=0 after one cycle and records are ignored; assert rstn=0 with a non-empty FIFO → all outputs 0 immediately.

Source files
------------

// File: rtl/cu_edge_data_accumulate_control.sv
// cu_edge_data_accumulate_control
//
// Purpose: sits after the edge-data read stage of the CSR PageRank push
// compute unit. It takes the (dest id, data) stream, which cannot be
// back-pressured, and merges consecutive updates to the same destination
// vertex into one running sum. Finished sums are queued in an output FIFO
// that feeds the vertex write-command stage. A flush/done handshake drains
// everything at the end of an iteration.
//
// Ports:
//   clock, rstn              clock, asynchronous active-low reset
//   enabled_in               block enable, used one cycle after it arrives
//   edge_valid_in            edge record valid (always accepted)
//   edge_cu_id_in/id/data    originating cu id, destination vertex, value
//   flush_in                 level request to drain accumulator and FIFO
//   write_ready_in           downstream accepts the head entry
//   write_valid_out          head entry valid
//   write_cu_id/id/data_out  head entry contents
//   almost_full_out          FIFO occupancy >= ALMOST_FULL_TH
//   overflow_out             sticky, an eviction was dropped
//   done_out                 flush complete
//   edge_count_out           accepted edge records (wraps)
module cu_edge_data_accumulate_control #(
  parameter int DATA_W         = 32,
  parameter int ID_W           = 32,
  parameter int CU_ID_W        = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int ALMOST_FULL_TH = 12
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic               enabled_in,
  input  logic               edge_valid_in,
  input  logic [CU_ID_W-1:0] edge_cu_id_in,
  input  logic [ID_W-1:0]    edge_id_in,
  input  logic [DATA_W-1:0]  edge_data_in,
  input  logic               flush_in,
  input  logic               write_ready_in,
  output logic               write_valid_out,
  output logic [CU_ID_W-1:0] write_cu_id_out,
  output logic [ID_W-1:0]    write_id_out,
  output logic [DATA_W-1:0]  write_data_out,
  output logic               almost_full_out,
  output logic               overflow_out,
  output logic               done_out,
  output logic [31:0]        edge_count_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FLUSH, ST_DONE} state_t;

  typedef struct packed {
    logic [CU_ID_W-1:0] cu_id;
    logic [ID_W-1:0]    id;
    logic [DATA_W-1:0]  data;
  } entry_t;

  logic               enabled_q;
  logic               s1_valid_q, s1_valid_d;
  logic [CU_ID_W-1:0] s1_cu_q, s1_cu_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [DATA_W-1:0]  s1_data_q, s1_data_d;
  logic               acc_valid_q, acc_valid_d;
  logic [CU_ID_W-1:0] acc_cu_q, acc_cu_d;
  logic [ID_W-1:0]    acc_id_q, acc_id_d;
  logic [DATA_W-1:0]  acc_sum_q, acc_sum_d;
  state_t             state_q, state_d;
  logic [31:0]        edge_count_q, edge_count_d;
  logic               overflow_q, overflow_d;
  entry_t             fifo_mem_q [FIFO_DEPTH];
  entry_t             fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic   push;
  logic   pop;
  logic   fifo_full;
  entry_t push_entry;

  // FIFO storage is reset too, so the head outputs read 0 straight out of reset.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_cu_q      <= '0;
      s1_id_q      <= '0;
      s1_data_q    <= '0;
      acc_valid_q  <= 1'b0;
      acc_cu_q     <= '0;
      acc_id_q     <= '0;
      acc_sum_q    <= '0;
      state_q      <= ST_IDLE;
      edge_count_q <= '0;
      overflow_q   <= 1'b0;
      fifo_mem_q   <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      enabled_q    <= enabled_in;
      s1_valid_q   <= s1_valid_d;
      s1_cu_q      <= s1_cu_d;
      s1_id_q      <= s1_id_d;
      s1_data_q    <= s1_data_d;
      acc_valid_q  <= acc_valid_d;
      acc_cu_q     <= acc_cu_d;
      acc_id_q     <= acc_id_d;
      acc_sum_q    <= acc_sum_d;
      state_q      <= state_d;
      edge_count_q <= edge_count_d;
      overflow_q   <= overflow_d;
      fifo_mem_q   <= fifo_mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  assign fifo_full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign write_valid_out = enabled_q && (count_q != '0);
  assign pop             = write_valid_out && write_ready_in;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_cu_d      = s1_cu_q;
    s1_id_d      = s1_id_q;
    s1_data_d    = s1_data_q;
    acc_valid_d  = acc_valid_q;
    acc_cu_d     = acc_cu_q;
    acc_id_d     = acc_id_q;
    acc_sum_d    = acc_sum_q;
    state_d      = state_q;
    edge_count_d = edge_count_q;
    overflow_d   = overflow_q;
    fifo_mem_d   = fifo_mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    push         = 1'b0;
    push_entry   = '{cu_id: acc_cu_q, id: acc_id_q, data: acc_sum_q};

    // While disabled nothing moves: no capture, no merge, no FSM step.
    if (enabled_q) begin
      s1_valid_d = edge_valid_in;
      s1_cu_d    = edge_cu_id_in;
      s1_id_d    = edge_id_in;
      s1_data_d  = edge_data_in;

      // An incoming record always wins over the flush-time eviction.
      if (s1_valid_q) begin
        edge_count_d = edge_count_q + 32'd1;
        if (acc_valid_q && (acc_id_q == s1_id_q)) begin
          acc_sum_d = acc_sum_q + s1_data_q;
        end else begin
          push        = acc_valid_q;
          acc_valid_d = 1'b1;
          acc_cu_d    = s1_cu_q;
          acc_id_d    = s1_id_q;
          acc_sum_d   = s1_data_q;
        end
      end else if ((state_q == ST_FLUSH) && acc_valid_q) begin
        push        = 1'b1;
        acc_valid_d = 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (flush_in)        state_d = ST_FLUSH;
          else if (s1_valid_q) state_d = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (flush_in) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (!s1_valid_q && !acc_valid_q && (count_q == '0)) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (s1_valid_q)     state_d = ST_FLUSH;
          else if (!flush_in) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Pop frees the head slot first, so a push at full with a pop still fits;
    // wr_ptr equals rd_ptr when full, and the old head is read out this cycle.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      if (fifo_full && !pop) begin
        overflow_d = 1'b1;
      end else begin
        fifo_mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
    end
    if (push && !fifo_full && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign write_cu_id_out = fifo_mem_q[rd_ptr_q].cu_id;
  assign write_id_out    = fifo_mem_q[rd_ptr_q].id;
  assign write_data_out  = fifo_mem_q[rd_ptr_q].data;
  assign almost_full_out = (count_q >= CNT_W'(ALMOST_FULL_TH));
  assign overflow_out    = overflow_q;
  assign done_out        = (state_q == ST_DONE);
  assign edge_count_out  = edge_count_q;

endmodule
